// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - round-robin sequencer sharing one 4-bit adder slice between two requesters
//
// Purpose: accepts WIDTH-bit add requests (WIDTH = 4*NIBBLES) from two requesters,
// performs each add nibble-serially (LSB nibble first) on an external combinational
// 4-bit full-adder slice, and returns the sum with a valid/ready handshake.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   reqN_valid/ready              request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin      operands and carry in, sampled only on the transfer cycle
//   res_valid/ready               result handshake
//   res_sum, res_cout, res_id     sum, final carry, owning requester (zero outside DONE)
//   busy                          high whenever the sequencer is not idle
//   slc_a, slc_b, slc_cin         drive the shared adder slice (zero outside RUN)
//   slc_s, slc_co                 combinational slice result

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,

    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_id,

    output logic                   busy,

    output logic [3:0]             slc_a,
    output logic [3:0]             slc_b,
    output logic                   slc_cin,
    input  logic [3:0]             slc_s,
    input  logic                   slc_co
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDXW  = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              id_q, id_d;
    logic              last_id_q, last_id_d;

    logic              grant;

    // Round robin: a lone requester always wins; on a tie the requester that
    // was not served last wins. last_id resets to 1 so requester 0 wins first.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_id_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = (state_q == IDLE) && req1_valid && (grant == 1'b1);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        id_d      = id_q;
        last_id_d = last_id_q;

        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    carry_d = req0_cin;
                    id_d    = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else if (req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    carry_d = req1_cin;
                    id_d    = 1'b1;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = slc_s;
                carry_d             = slc_co;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    last_id_d = id_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
        end
    end

    // Slice inputs are forced to zero outside RUN so the shared adder sees
    // no stale operands while idle or holding a result.
    assign slc_a   = (state_q == RUN) ? a_q[4*idx_q +: 4] : 4'd0;
    assign slc_b   = (state_q == RUN) ? b_q[4*idx_q +: 4] : 4'd0;
    assign slc_cin = (state_q == RUN) ? carry_q : 1'b0;

    // Result fields are gated so that every output reads zero while no result is offered.
    assign res_valid = (state_q == DONE);
    assign res_sum   = (state_q == DONE) ? sum_q : '0;
    assign res_cout  = (state_q == DONE) ? carry_q : 1'b0;
    assign res_id    = (state_q == DONE) ? id_q : 1'b0;

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed self-checking bench for nibble_serial_add_ctrl

module tb_nibble_serial_add_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_cin;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_cin;
    logic [W-1:0]  req1_a, req1_b;
    logic          res_valid, res_ready, res_cout, res_id, busy;
    logic [W-1:0]  res_sum;
    logic [3:0]    slc_a, slc_b, slc_s;
    logic          slc_cin, slc_co;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // External combinational 4-bit adder slice
    assign {slc_co, slc_s} = {1'b0, slc_a} + {1'b0, slc_b} + {4'b0000, slc_cin};

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy),
        .slc_a      (slc_a),
        .slc_b      (slc_b),
        .slc_cin    (slc_cin),
        .slc_s      (slc_s),
        .slc_co     (slc_co)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_sum"},   res_sum,   '0);
        check({tag, "_res_cout"},  res_cout,  1'b0);
        check({tag, "_res_id"},    res_id,    1'b0);
        check({tag, "_slc_a"},     slc_a,     4'd0);
        check({tag, "_slc_b"},     slc_b,     4'd0);
        check({tag, "_slc_cin"},   slc_cin,   1'b0);
    endtask

    // Starts at a negedge in IDLE; ends at a negedge back in IDLE.
    task automatic do_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit cin, input logic [W-1:0] exp_sum, input bit exp_cout,
                         input int bp);
        int   lat;
        logic c;
        logic [4:0] nib_sum;
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        #1;
        check("ready_granted", who ? req1_ready : req0_ready, 1'b1);
        check("ready_other",   who ? req0_ready : req1_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        // Operands change after transfer; the result must not be affected.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        req0_cin = ~cin; req1_cin = ~cin;
        lat = 1;
        c   = cin;
        while (!res_valid && lat <= 20) begin
            check("run_busy", busy, 1'b1);
            if (lat <= NIB) begin
                check("slc_a",   slc_a,   a[4*(lat-1) +: 4]);
                check("slc_b",   slc_b,   b[4*(lat-1) +: 4]);
                check("slc_cin", slc_cin, c);
                nib_sum = {1'b0, a[4*(lat-1) +: 4]} + {1'b0, b[4*(lat-1) +: 4]} + {4'b0000, c};
                c = nib_sum[4];
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NIB + 1);
        for (int i = 0; i <= bp; i++) begin
            if (i < bp) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
                #1;
                check("bp_req0_ready", req0_ready, 1'b0);
                check("bp_req1_ready", req1_ready, 1'b0);
            end
            check("res_valid", res_valid, 1'b1);
            check("res_sum",   res_sum,   exp_sum);
            check("res_cout",  res_cout,  exp_cout);
            check("res_id",    res_id,    who);
            check("done_busy", busy,      1'b1);
            check("done_slc_a", slc_a,    4'd0);
            check("done_slc_cin", slc_cin, 1'b0);
            if (i < bp) @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check_idle_outputs("after_hs");
    endtask

    initial begin
        int  g;
        int  cyc;
        int  seen;
        bit  prev_rdy;
        bit  gid[4];
        bit  exp_gid[4];

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready = 1'b0;

        do_reset();
        check_idle_outputs("reset");
        check("reset_req0_ready", req0_ready, 1'b0);
        check("reset_req1_ready", req1_ready, 1'b0);

        do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 0);
        do_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0);
        do_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
        do_op(1'b0, 16'h4321, 16'h8765, 1'b0, 16'hCA86, 1'b0, 3);
        do_op(1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 0);

        // Arbitration: both requesters held valid after reset
        do_reset();
        req0_a = 16'h0010; req0_b = 16'h0002; req0_cin = 1'b0;
        req1_a = 16'h0020; req1_b = 16'h0002; req1_cin = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        res_ready = 1'b1;
        exp_gid = '{1'b0, 1'b1, 1'b0, 1'b1};
        g = 0; cyc = 0; prev_rdy = 1'b0;
        while (g < 4 && cyc < 100) begin
            #1;
            check("one_ready", req0_ready & req1_ready, 1'b0);
            if (req0_ready || req1_ready) begin
                check("ready_pulse", prev_rdy, 1'b0);
                gid[g] = req1_ready;
                g++;
            end
            if (res_valid) begin
                check("arb_sum", res_sum, res_id ? 16'h0022 : 16'h0012);
            end
            prev_rdy = req0_ready | req1_ready;
            @(negedge clk);
            cyc++;
        end
        check("arb_grants", g, 4);
        for (int i = 0; i < 4; i++) begin
            check("arb_order", gid[i], exp_gid[i]);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("arb_drain", busy, 1'b0);
        res_ready = 1'b0;

        // Reset in the middle of an operation
        req0_valid = 1'b1; req0_a = 16'h4321; req0_b = 16'h8765; req0_cin = 1'b0;
        #1;
        check("mid_ready", req0_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_slc_a_idx2", slc_a, 4'h3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        seen = 0;
        res_ready = 1'b1;
        repeat (8) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        res_ready = 1'b0;
        check("mid_no_result", seen, 0);

        req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0200; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0300; req1_b = 16'h0400; req1_cin = 1'b0;
        #1;
        check("tie_req0_ready", req0_ready, 1'b1);
        check("tie_req1_ready", req1_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("tie_res_valid", res_valid, 1'b1);
        check("tie_res_id",    res_id,    1'b0);
        check("tie_res_sum",   res_sum,   16'h0300);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("tie_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer and arbiter that shares one external 4-bit combinational full-adder slice between two requesters.
- Each accepted request is a WIDTH-bit add (WIDTH = 4*NIBBLES), performed nibble-serially, LSB nibble first.
- Carry is registered between nibbles.
- Round-robin arbitration on the request side; valid/ready handshake on the result side.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; WIDTH = 4*NIBBLES; legal range 2..16.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_cin  in  1  carry in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  sum.
- res_cout  out  1  final carry out.
- res_id  out  1  requester that owns the result.
- busy  out  1  high when state is not IDLE.
- slc_a  out  4  adder slice operand A.
- slc_b  out  4  adder slice operand B.
- slc_cin  out  1  adder slice carry in.
- slc_s  in  4  adder slice sum (combinational from the slc_* outputs).
- slc_co  in  1  adder slice carry out.

Behaviour:
- Reset: one clock, synchronous, active-high, per the fixed decision above. On reset:
  - state=IDLE; all outputs 0.
  - a_reg, b_reg, sum_reg, carry, idx, id all 0.
  - last_id=1, so requester 0 wins the first tie.
- reset is a synchronous, active-high clear to this state from any state. A partial result is discarded and res_valid is never asserted for it.
- States: IDLE, RUN, DONE.
- IDLE, arbitration (combinational):
  - grant = the only valid requester; if both valid, the requester != last_id.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready per cycle.
  - On transfer: capture a, b into a_reg, b_reg; carry<=cin; id<=N; idx<=0; sum_reg<=0; go to RUN.
- RUN, one nibble per cycle:
  - slc_a = a_reg[4*idx+:4], slc_b = b_reg[4*idx+:4], slc_cin = carry.
  - At the clock edge: sum_reg[4*idx+:4]<=slc_s; carry<=slc_co; idx<=idx+1.
  - When idx==NIBBLES-1, go to DONE instead of incrementing.
- Outside RUN: slc_a=0, slc_b=0, slc_cin=0.
- DONE:
  - res_valid=1; res_sum=sum_reg; res_cout=carry; res_id=id. All stable while res_ready=0.
  - On res_valid&&res_ready: last_id<=id; go to IDLE. The next request transfer is possible the following cycle.
- Latency: transfer in cycle T gives RUN in cycles T+1..T+NIBBLES and res_valid first high at T+NIBBLES+1.
- Minimum spacing is NIBBLES+2 cycles per operation.
- Arithmetic: {res_cout,res_sum} == a + b + cin, modulo 2^(WIDTH+1). Overflow is reported only through cout.
- Requester inputs are sampled only on the transfer cycle; later changes are ignored.
- A requester that drops valid in IDLE before a grant is legal; no transfer occurs.
- No request is accepted in RUN or DONE; both readys stay 0.
- res_valid is held until the handshake; it never drops without res_ready.
- Fairness: with both valid continuously, grants alternate 0,1,0,1. A requester alone is served back-to-back.

Test Plan:
- Single op: req0 a=0x1234, b=0x0FFF, cin=0 -> res_sum=0x2233, res_cout=0, res_id=0. res_valid first high exactly 5 cycles after the transfer cycle. busy high for the whole interval.
- Ripple carry: req1 a=0xFFFF, b=0x0000, cin=1 -> res_sum=0x0000, res_cout=1, res_id=1.
  - Also a=0xFFFF, b=0xFFFF, cin=1 -> res_sum=0xFFFF, res_cout=1.
- Slice sequencing: a=0x4321, b=0x8765 -> slc_a=1,2,3,4 and slc_b=5,6,7,8 over the 4 RUN cycles. slc_cin follows the registered carry. slc_* are 0 in IDLE and DONE.
- Arbitration: after reset, hold both valid with res_ready=1 -> ids served 0,1,0,1. Each readyN pulses for one cycle only, and never both readys in the same cycle.
- Backpressure: res_ready=0 for 3 cycles in DONE -> res_valid, res_sum, res_cout, res_id stable. req readys stay 0. On res_ready=1 the state returns to IDLE the next cycle.
- Reset mid-op: assert rst at RUN idx=2 -> next cycle IDLE, all outputs 0, last_id=1, no res_valid. A subsequent tie grants requester 0.
